// File: rtl/serial_op_sequencer_pkg.sv
// Shared definitions for the bit-serial operation sequencer: state encoding and default word length.
package serial_op_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_op_sequencer_counter.sv
// Bit index counter for the serial datapath; clear has priority over increment.
module seq_bit_counter
  import serial_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_op_sequencer.sv
// Control FSM for the bit-serial datapath: load, WIDTH shift cycles, then hold the result
// until the consumer accepts it. Outputs are registered copies of the next-state decode.
module serial_op_sequencer
  import serial_op_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             result_ready,
  output logic             load,
  output logic             carry_clr,
  output logic             shift_en,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t state_q, state_d;
  logic   load_q, load_d;
  logic   carry_clr_q, carry_clr_d;
  logic   shift_en_q, shift_en_d;
  logic   busy_q, busy_d;
  logic   result_valid_q, result_valid_d;
  logic   cnt_clr, cnt_inc, cnt_last;

  seq_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .count (bit_cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_clr = 1'b1;
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          cnt_clr = 1'b1;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          // The counter stops on the last bit so it never wraps inside SHIFT.
          if (cnt_last) state_d = S_DONE;
          else          cnt_inc = 1'b1;
        end
        S_DONE: begin
          if (result_ready) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end

    // Decoding the next state keeps the registered outputs aligned with state_q.
    load_d         = (state_d == S_LOAD);
    carry_clr_d    = (state_d == S_LOAD);
    shift_en_d     = (state_d == S_SHIFT);
    result_valid_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      load_q         <= 1'b0;
      carry_clr_q    <= 1'b0;
      shift_en_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_q         <= load_d;
      carry_clr_q    <= carry_clr_d;
      shift_en_q     <= shift_en_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign load         = load_q;
  assign carry_clr    = carry_clr_q;
  assign shift_en     = shift_en_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_serial_op_sequencer.sv
// Bench for serial_op_sequencer: drives a bit-serial adder from the sequencer outputs
// and scores the captured sums against expected results queued at start time.
module tb_serial_op_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             result_ready = 1'b0;
  logic             load, carry_clr, shift_en, busy, result_valid;
  logic [CNT_W-1:0] bit_cnt;

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0] op_a = '0, op_b = '0;
  logic [WIDTH-1:0] a_sr = '0, b_sr = '0, r_sr = '0;
  logic             carry = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .result_ready (result_ready),
    .load         (load),
    .carry_clr    (carry_clr),
    .shift_en     (shift_en),
    .busy         (busy),
    .result_valid (result_valid),
    .bit_cnt      (bit_cnt)
  );

  // LSB-first serial adder controlled by the sequencer strobes.
  always @(posedge clk) begin
    if (load) begin
      a_sr <= op_a;
      b_sr <= op_b;
    end else if (shift_en) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= {a_sr[0] ^ b_sr[0] ^ carry, r_sr[WIDTH-1:1]};
      carry <= (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end
    if (carry_clr) carry <= 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    int         bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    repeat (3) step();
    outs = {load, carry_clr, shift_en, busy, result_valid, bit_cnt};
    checks++;
    if (outs !== 8'h00) $display("FAIL reset_outputs: got %h, expected 00", outs);
    else passed++;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_idle: busy=%b, expected 0", busy);
    else passed++;
    $display("reset: outputs=%h after reset, busy=%b after release", outs, busy);

    // Reset in the middle of a shift sequence.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !(shift_en && bit_cnt == 3'd4); i++) step();
    checks++;
    if (!(shift_en === 1'b1 && bit_cnt === 3'd4))
      $display("FAIL reset_reach_bit4: shift_en=%b bit_cnt=%0d, expected 1/4", shift_en, bit_cnt);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    outs = {load, carry_clr, shift_en, busy, result_valid, bit_cnt};
    checks++;
    if (outs !== 8'h00) $display("FAIL reset_async_midshift: got %h, expected 00", outs);
    else passed++;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_no_partial_result: %0d bad cycles, expected 0", bad);
    else passed++;
    $display("reset mid-shift: outputs=%h same cycle, bad idle cycles=%0d", outs, bad);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int ready_delay, input bit hold_start, input string name);
    int               cyc, loads, shifts, clr_bad, bad;
    logic [WIDTH-1:0] exp_sum;
    op_a = a;
    op_b = b;
    exp_q.push_back(a + b);
    result_ready = (ready_delay == 0);
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    cyc = 1; loads = 0; shifts = 0; clr_bad = 0;
    while (!result_valid && cyc < 4 * WIDTH) begin
      if (load) begin
        loads++;
        if (carry_clr !== 1'b1 || cyc != 1) clr_bad++;
      end
      if (shift_en) begin
        checks++;
        if (bit_cnt !== CNT_W'(shifts))
          $display("FAIL %s_bit_cnt: got %0d, expected %0d", name, bit_cnt, shifts);
        else passed++;
        shifts++;
      end
      step();
      cyc++;
    end
    checks++;
    if (loads != 1 || clr_bad != 0)
      $display("FAIL %s_load: loads=%0d clr_bad=%0d, expected 1/0", name, loads, clr_bad);
    else passed++;
    checks++;
    if (shifts != WIDTH) $display("FAIL %s_shift_count: got %0d, expected %0d", name, shifts, WIDTH);
    else passed++;
    checks++;
    if (result_valid !== 1'b1 || cyc != WIDTH + 2)
      $display("FAIL %s_latency: valid=%b at sample %0d, expected 1 at %0d", name, result_valid, cyc, WIDTH + 2);
    else passed++;
    exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (r_sr !== exp_sum) $display("FAIL %s_result: got %h, expected %h", name, r_sr, exp_sum);
    else passed++;
    $display("%s: %h+%h -> %h (exp %h), shifts=%0d, valid at sample %0d",
             name, a, b, r_sr, exp_sum, shifts, cyc);

    if (ready_delay > 0) begin
      bad = 0;
      for (int i = 0; i < ready_delay; i++) begin
        if (result_valid !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b1 || load !== 1'b0) bad++;
        step();
      end
      if (result_valid !== 1'b1 || shift_en !== 1'b0) bad++;
      checks++;
      if (bad != 0) $display("FAIL %s_backpressure: %0d bad cycles, expected 0", name, bad);
      else passed++;
      $display("%s: held DONE %0d cycles, bad=%0d", name, ready_delay, bad);
      result_ready = 1'b1;
    end
    step();
    if (hold_start) start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL %s_accept_idle: busy=%b valid=%b, expected 0/0", name, busy, result_valid);
    else passed++;
    step();
    checks++;
    if (load !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_no_reload: load=%b busy=%b, expected 0/0", name, load, busy);
    else passed++;
    result_ready = 1'b0;
  endtask

  task automatic test_basic();
    run_op(8'hA5, 8'h3C, 0, 1'b0, "basic_a5_3c");
    run_op(8'hFF, 8'h01, 0, 1'b0, "basic_overflow");
    run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1'b0, "basic_random");
  endtask

  task automatic test_backpressure();
    run_op(8'h12, 8'h34, 5, 1'b0, "backpressure");
  endtask

  task automatic test_start_ignored();
    run_op(8'h5A, 8'h5A, 2, 1'b1, "start_ignored");
  endtask

  task automatic test_abort();
    int bad;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (load !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_beats_start: load=%b busy=%b, expected 0/0", load, busy);
    else passed++;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !(shift_en && bit_cnt == 3'd3); i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || shift_en !== 1'b0 || bit_cnt !== 3'd0)
      $display("FAIL abort_midshift: busy=%b shift_en=%b bit_cnt=%0d, expected 0/0/0", busy, shift_en, bit_cnt);
    else passed++;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL abort_no_result: %0d bad cycles, expected 0", bad);
    else passed++;
    $display("abort at bit 3: busy=%b, bad cycles afterwards=%0d", busy, bad);
  endtask

  task automatic test_back_to_back();
    int               nres, idle_gap, cyc;
    logic             prev_valid;
    logic [WIDTH-1:0] exp_sum;
    op_a = 8'h0F;
    op_b = 8'hF1;
    exp_q.push_back(op_a + op_b);
    exp_q.push_back(op_a + op_b);
    result_ready = 1'b1;
    start = 1'b1;
    nres = 0; idle_gap = 0; cyc = 0; prev_valid = 1'b0;
    while (nres < 2 && cyc < 4 * (WIDTH + 4)) begin
      step();
      cyc++;
      if (result_valid && !prev_valid) begin
        exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (r_sr !== exp_sum) $display("FAIL b2b_result%0d: got %h, expected %h", nres, r_sr, exp_sum);
        else passed++;
        $display("back_to_back op %0d: result %h (exp %h)", nres, r_sr, exp_sum);
        nres++;
      end
      if (nres == 1 && !busy) idle_gap++;
      prev_valid = result_valid;
    end
    start = 1'b0;
    checks++;
    if (nres != 2) $display("FAIL b2b_count: got %0d results, expected 2", nres);
    else passed++;
    checks++;
    if (idle_gap != 1) $display("FAIL b2b_gap: got %0d idle cycles, expected 1", idle_gap);
    else passed++;
    $display("back_to_back: %0d results, idle gap %0d", nres, idle_gap);
    step();
    step();
    result_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_final_idle: busy=%b, expected 0", busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
